// File: rtl/dm_multihart_if.sv
// DMI and hart-side debug bus handshake signals for dm_multihart.
interface dm_multihart_if;
  logic        dmi_valid;
  logic        dmi_ready;
  logic        dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_write;
  logic [17:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    input  dmi_ready, dmi_rdata,
    output bus_valid, bus_write, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    output dmi_ready, dmi_rdata,
    input  bus_valid, bus_write, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dm_multihart.sv
// Multi-hart debug module core: DMI register file, per-hart halt/resume
// tracking, abstract-command FSM and a mailbox polled by the debug ROM.
// Optional feature: define DM_AUTOEXEC_EN to add abstractauto (DMI 0x18).
module dm_multihart #(
  parameter int unsigned NUM_HART = 4,
  parameter int unsigned NUM_DATA = 2
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [NUM_HART-1:0] interrupt,
  dm_multihart_if.slave       dm
);

  localparam int unsigned HSW       = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;
  localparam int unsigned DATA0_DMI = 4;
  localparam int unsigned DATA0_BUS = 32'h0E0;

  localparam logic [6:0]  A_DMCONTROL = 7'h10;
  localparam logic [6:0]  A_DMSTATUS  = 7'h11;
  localparam logic [6:0]  A_ABSCS     = 7'h16;
  localparam logic [6:0]  A_COMMAND   = 7'h17;
  localparam logic [6:0]  A_ABSAUTO   = 7'h18;

  localparam logic [17:0] B_REQUEST = 18'h000C0;
  localparam logic [17:0] B_ARG     = 18'h000C1;
  localparam logic [17:0] B_HALT    = 18'h000C2;
  localparam logic [17:0] B_RESUME  = 18'h000C3;
  localparam logic [17:0] B_DONE    = 18'h000C4;
  localparam logic [17:0] B_EXCEPT  = 18'h000C5;

  localparam logic [5:0] REQ_RESUME  = 6'h01;
  localparam logic [5:0] REQ_GET_REG = 6'h02;
  localparam logic [5:0] REQ_SET_REG = 6'h03;
  localparam logic [5:0] REQ_GET_MEM = 6'h04;
  localparam logic [5:0] REQ_SET_MEM = 6'h05;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_n;
  logic                dmactive_q, dmactive_n;
  logic [HSW-1:0]      hartsel_q, hartsel_n;
  logic [NUM_HART-1:0] haltreq_q, haltreq_n;
  logic [NUM_HART-1:0] hart_halt_q, hart_halt_n;
  logic [NUM_HART-1:0] resumeack_q, resumeack_n;
  logic [2:0]          cmderr_q, cmderr_n;
  logic [31:0]         data_q [NUM_DATA];
  logic [31:0]         data_n [NUM_DATA];
  logic                mbox_valid_q, mbox_valid_n;
  logic [5:0]          mbox_num_q, mbox_num_n;
  logic [HSW-1:0]      mbox_hart_q, mbox_hart_n;
  logic [19:0]         arg_q, arg_n;
  logic [NUM_DATA-1:0] auto_bits;
`ifdef DM_AUTOEXEC_EN
  logic [NUM_DATA-1:0] autoexec_q, autoexec_n;
  logic [31:0]         last_cmd_q, last_cmd_n;
`endif

  logic        dmi_ready_q, bus_ready_q;
  logic [31:0] dmi_rdata_q, bus_rdata_q;
  logic [31:0] dmi_rd, bus_rd;
  logic [HSW-1:0] hs_new;
  logic        sel_halted, sel_exists, sel_ack, sel_haltreq, new_halted;
  logic        acc_dmi, acc_dmi_wr, acc_bus_wr;
  logic        issue;
  logic [31:0] issue_cmd;
  logic [2:0]  err;

  assign dm.dmi_ready = dmi_ready_q;
  assign dm.dmi_rdata = dmi_rdata_q;
  assign dm.bus_ready = bus_ready_q;
  assign dm.bus_rdata = bus_rdata_q;
  assign hs_new       = HSW'(dm.dmi_wdata[25:16]);
  assign acc_dmi      = dm.dmi_valid && dmi_ready_q;
  assign acc_dmi_wr   = acc_dmi && dm.dmi_write;
  assign acc_bus_wr   = dm.bus_valid && bus_ready_q && dm.bus_write;
`ifdef DM_AUTOEXEC_EN
  assign auto_bits    = autoexec_q;
`else
  assign auto_bits    = '0;
`endif

  // Abstract-command legality checks that do not depend on FSM/cmderr state.
  function automatic logic [2:0] cmd_check(input logic [31:0] cmd, input logic halted);
    logic [2:0] e;
    e = 3'd0;
    if (cmd[31:24] != 8'd0 && cmd[31:24] != 8'd2) e = 3'd2;
    else if (cmd[31:24] == 8'd0 && cmd[15:0] >= 16'h1020) e = 3'd2;
    else if (!halted) e = 3'd4;
    return e;
  endfunction

  // Per-hart status of the currently selected hart and of the hart being selected.
  always_comb begin
    sel_halted  = 1'b0;
    sel_exists  = 1'b0;
    sel_ack     = 1'b0;
    sel_haltreq = 1'b0;
    new_halted  = 1'b0;
    for (int h = 0; h < int'(NUM_HART); h++) begin
      if (hartsel_q == HSW'(h)) begin
        sel_exists  = 1'b1;
        sel_halted  = hart_halt_q[h];
        sel_ack     = resumeack_q[h];
        sel_haltreq = haltreq_q[h];
      end
      if (hs_new == HSW'(h)) new_halted = hart_halt_q[h];
    end
  end

  // DMI read mux.
  always_comb begin
    dmi_rd = 32'd0;
    case (dm.dmi_addr)
      A_DMCONTROL: dmi_rd = {sel_haltreq, 5'b0, 10'(hartsel_q), 15'b0, dmactive_q};
      A_DMSTATUS:  dmi_rd = {14'b0, sel_ack, sel_ack, 4'b0,
                             sel_exists && !sel_halted, sel_exists && !sel_halted,
                             sel_halted, sel_halted, 8'b0};
      A_ABSCS:     dmi_rd = {19'b0, state_q == BUSY, 1'b0, cmderr_q, 4'b0, 4'(NUM_DATA)};
`ifdef DM_AUTOEXEC_EN
      A_ABSAUTO:   dmi_rd = 32'(autoexec_q);
`endif
      default:     dmi_rd = 32'd0;
    endcase
    for (int i = 0; i < int'(NUM_DATA); i++)
      if (dm.dmi_addr == 7'(DATA0_DMI + i)) dmi_rd = data_q[i];
  end

  // Hart bus read mux.
  always_comb begin
    bus_rd = 32'd0;
    case (dm.bus_addr)
      B_REQUEST: bus_rd = {mbox_valid_q, 5'b0, mbox_num_q, 20'(mbox_hart_q)};
      B_ARG:     bus_rd = 32'(arg_q);
      default:   bus_rd = 32'd0;
    endcase
    for (int i = 0; i < int'(NUM_DATA); i++)
      if (dm.bus_addr == 18'(DATA0_BUS + i)) bus_rd = data_q[i];
  end

  // Next-state: bus effects first, then DMI effects so the DMI side wins conflicts.
  always_comb begin
    state_n      = state_q;
    dmactive_n   = dmactive_q;
    hartsel_n    = hartsel_q;
    haltreq_n    = haltreq_q;
    hart_halt_n  = hart_halt_q;
    resumeack_n  = resumeack_q;
    cmderr_n     = cmderr_q;
    data_n       = data_q;
    mbox_valid_n = mbox_valid_q;
    mbox_num_n   = mbox_num_q;
    mbox_hart_n  = mbox_hart_q;
    arg_n        = arg_q;
    issue        = 1'b0;
    issue_cmd    = dm.dmi_wdata;
    err          = 3'd0;
`ifdef DM_AUTOEXEC_EN
    autoexec_n   = autoexec_q;
    last_cmd_n   = last_cmd_q;
`endif

    if (acc_bus_wr) begin
      case (dm.bus_addr)
        B_REQUEST: mbox_valid_n = 1'b0;
        B_HALT:
          for (int h = 0; h < int'(NUM_HART); h++)
            if (dm.bus_wdata == 32'(h)) hart_halt_n[h] = 1'b1;
        B_RESUME:
          for (int h = 0; h < int'(NUM_HART); h++)
            if (dm.bus_wdata == 32'(h)) begin
              hart_halt_n[h] = 1'b0;
              resumeack_n[h] = 1'b1;
            end
        B_DONE:
          if (state_q == BUSY) state_n = IDLE;
        B_EXCEPT:
          if (state_q == BUSY) begin
            state_n  = IDLE;
            cmderr_n = 3'd3;
          end
        default: ;
      endcase
      for (int i = 0; i < int'(NUM_DATA); i++)
        if (dm.bus_addr == 18'(DATA0_BUS + i)) data_n[i] = dm.bus_wdata;
    end

    if (acc_dmi_wr) begin
      case (dm.dmi_addr)
        A_DMCONTROL:
          if (!dm.dmi_wdata[0]) begin
            dmactive_n = 1'b0;
            haltreq_n  = '0;
            hartsel_n  = '0;
            cmderr_n   = 3'd0;
            state_n    = IDLE;
          end else begin
            dmactive_n = 1'b1;
            hartsel_n  = hs_new;
            for (int h = 0; h < int'(NUM_HART); h++)
              if (hs_new == HSW'(h)) haltreq_n[h] = dm.dmi_wdata[31];
            if (dm.dmi_wdata[30] && new_halted && state_q == IDLE) begin
              for (int h = 0; h < int'(NUM_HART); h++)
                if (hs_new == HSW'(h)) resumeack_n[h] = 1'b0;
              mbox_valid_n = 1'b1;
              mbox_num_n   = REQ_RESUME;
              mbox_hart_n  = hs_new;
            end
          end
        A_ABSCS:   cmderr_n = cmderr_n & ~dm.dmi_wdata[10:8];
        A_COMMAND: begin
          issue = 1'b1;
`ifdef DM_AUTOEXEC_EN
          if (cmderr_q == 3'd0 && state_q == IDLE) last_cmd_n = dm.dmi_wdata;
`endif
        end
`ifdef DM_AUTOEXEC_EN
        A_ABSAUTO: autoexec_n = dm.dmi_wdata[NUM_DATA-1:0];
`endif
        default: ;
      endcase
    end

    // Data register access from DMI, including the busy-collision error.
    for (int i = 0; i < int'(NUM_DATA); i++) begin
      if (acc_dmi && dm.dmi_addr == 7'(DATA0_DMI + i)) begin
        if (state_q == BUSY) begin
          if ((dm.dmi_write || auto_bits[i]) && cmderr_q == 3'd0) cmderr_n = 3'd1;
        end else begin
          if (dm.dmi_write) data_n[i] = dm.dmi_wdata;
`ifdef DM_AUTOEXEC_EN
          if (autoexec_q[i] && cmderr_q == 3'd0) begin
            issue     = 1'b1;
            issue_cmd = last_cmd_q;
          end
`endif
        end
      end
    end

    // Abstract command issue: checks in priority order, then post to mailbox.
    if (issue && cmderr_q == 3'd0) begin
      if (state_q == BUSY) begin
        cmderr_n = 3'd1;
      end else begin
        err = cmd_check(issue_cmd, sel_halted);
        if (err != 3'd0) begin
          cmderr_n = err;
        end else if (!(issue_cmd[31:24] == 8'd0 && !issue_cmd[17])) begin
          state_n      = BUSY;
          mbox_valid_n = 1'b1;
          mbox_hart_n  = hartsel_q;
          arg_n        = {issue_cmd[16], issue_cmd[22:20], issue_cmd[15:0]};
          if (issue_cmd[31:24] == 8'd0) mbox_num_n = issue_cmd[16] ? REQ_SET_REG : REQ_GET_REG;
          else                          mbox_num_n = issue_cmd[16] ? REQ_SET_MEM : REQ_GET_MEM;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      dmactive_q   <= 1'b0;
      hartsel_q    <= '0;
      haltreq_q    <= '0;
      hart_halt_q  <= '0;
      resumeack_q  <= '0;
      cmderr_q     <= 3'd0;
      for (int i = 0; i < int'(NUM_DATA); i++) data_q[i] <= 32'd0;
      mbox_valid_q <= 1'b0;
      mbox_num_q   <= 6'd0;
      mbox_hart_q  <= '0;
      arg_q        <= 20'd0;
`ifdef DM_AUTOEXEC_EN
      autoexec_q   <= '0;
      last_cmd_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_n;
      dmactive_q   <= dmactive_n;
      hartsel_q    <= hartsel_n;
      haltreq_q    <= haltreq_n;
      hart_halt_q  <= hart_halt_n;
      resumeack_q  <= resumeack_n;
      cmderr_q     <= cmderr_n;
      data_q       <= data_n;
      mbox_valid_q <= mbox_valid_n;
      mbox_num_q   <= mbox_num_n;
      mbox_hart_q  <= mbox_hart_n;
      arg_q        <= arg_n;
`ifdef DM_AUTOEXEC_EN
      autoexec_q   <= autoexec_n;
      last_cmd_q   <= last_cmd_n;
`endif
    end
  end

  // Handshake: one-cycle ready pulse after valid, read data captured with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dmi_ready_q <= 1'b0;
      dmi_rdata_q <= 32'd0;
      bus_ready_q <= 1'b0;
      bus_rdata_q <= 32'd0;
      interrupt   <= '0;
    end else begin
      dmi_ready_q <= dm.dmi_valid && !dmi_ready_q;
      bus_ready_q <= dm.bus_valid && !bus_ready_q;
      if (dm.dmi_valid && !dmi_ready_q) dmi_rdata_q <= dmi_rd;
      if (dm.bus_valid && !bus_ready_q) bus_rdata_q <= bus_rd;
      interrupt   <= haltreq_q;
    end
  end

endmodule

// File: tb/tb_dm_multihart.sv
// Directed self-checking bench for dm_multihart (NUM_HART=4, NUM_DATA=2).
module tb_dm_multihart;
  localparam int unsigned NUM_HART = 4;
  localparam int unsigned NUM_DATA = 2;

  logic                clk = 1'b0;
  logic                resetn;
  logic [NUM_HART-1:0] interrupt;
  int                  n_checks = 0;
  int                  n_errors = 0;

  dm_multihart_if dm_if();

  dm_multihart #(.NUM_HART(NUM_HART), .NUM_DATA(NUM_DATA)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .interrupt (interrupt),
    .dm        (dm_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic dmi_xfer(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    bit seen;
    seen = 1'b0;
    rd   = 32'd0;
    @(negedge clk);
    dm_if.dmi_valid = 1'b1;
    dm_if.dmi_write = wr;
    dm_if.dmi_addr  = a;
    dm_if.dmi_wdata = wd;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (dm_if.dmi_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL dmi_timeout: addr 0x%02h ready never rose", a);
    end else begin
      rd = dm_if.dmi_rdata;
    end
    @(negedge clk);
    dm_if.dmi_valid = 1'b0;
    dm_if.dmi_write = 1'b0;
  endtask

  task automatic bus_xfer(input logic wr, input logic [19:0] byte_a, input logic [31:0] wd,
                          output logic [31:0] rd);
    bit seen;
    seen = 1'b0;
    rd   = 32'd0;
    @(negedge clk);
    dm_if.bus_valid = 1'b1;
    dm_if.bus_write = wr;
    dm_if.bus_addr  = byte_a[19:2];
    dm_if.bus_wdata = wd;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (dm_if.bus_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL bus_timeout: addr 0x%05h ready never rose", byte_a);
    end else begin
      rd = dm_if.bus_rdata;
    end
    @(negedge clk);
    dm_if.bus_valid = 1'b0;
    dm_if.bus_write = 1'b0;
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] tmp;
    dmi_xfer(1'b1, a, d, tmp);
  endtask

  task automatic dmi_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    dmi_xfer(1'b0, a, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
    logic [31:0] tmp;
    bus_xfer(1'b1, a, d, tmp);
  endtask

  task automatic bus_chk(input string tag, input logic [19:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(1'b0, a, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic irq_chk(input string tag, input logic [NUM_HART-1:0] exp);
    repeat (2) @(negedge clk);
    check(tag, 32'(interrupt), 32'(exp));
  endtask

  initial begin
    resetn          = 1'b0;
    dm_if.dmi_valid = 1'b0;
    dm_if.dmi_write = 1'b0;
    dm_if.dmi_addr  = 7'd0;
    dm_if.dmi_wdata = 32'd0;
    dm_if.bus_valid = 1'b0;
    dm_if.bus_write = 1'b0;
    dm_if.bus_addr  = 18'd0;
    dm_if.bus_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_irq",       32'(interrupt), 32'd0);
    check("rst_dmi_ready", 32'(dm_if.dmi_ready), 32'd0);
    check("rst_bus_rdata", dm_if.bus_rdata, 32'd0);
    resetn = 1'b1;

    dmi_chk("rst_dmstatus", 7'h11, 32'h0000_0C00);
    dmi_chk("rst_abscs",    7'h16, 32'h0000_0002);
    bus_chk("rst_request",  20'h300, 32'h0000_0000);

    // Halt request for hart 0, then hart 0 reports halted.
    dmi_wr(7'h10, 32'h0000_0001);
    dmi_wr(7'h10, 32'h8000_0001);
    irq_chk("irq_hart0", 4'b0001);
    dmi_chk("dmcontrol_rb", 7'h10, 32'h8000_0001);
    bus_wr(20'h308, 32'd0);
    dmi_chk("dmstatus_h0_halted", 7'h11, 32'h0000_0300);

    // Access-register write on halted hart 2.
    bus_wr(20'h308, 32'd2);
    dmi_wr(7'h10, 32'h0002_0001);
    irq_chk("irq_keep_h0", 4'b0001);
    dmi_wr(7'h17, 32'h0023_1008);
    dmi_chk("abscs_busy",  7'h16, 32'h0000_1002);
    bus_chk("req_setreg",  20'h300, 32'h8030_0002);
    bus_chk("arg_setreg",  20'h304, 32'h000A_1008);

    // Command while busy.
    dmi_wr(7'h17, 32'h0022_1008);
    dmi_chk("abscs_busy_err", 7'h16, 32'h0000_1102);
    bus_chk("req_unchanged",  20'h300, 32'h8030_0002);
    bus_wr(20'h310, 32'd0);
    dmi_chk("abscs_done",   7'h16, 32'h0000_0102);
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_chk("abscs_w1c",    7'h16, 32'h0000_0002);

    // Data registers from both sides.
    bus_wr(20'h380, 32'hDEAD_BEEF);
    dmi_chk("data0_from_bus", 7'h04, 32'hDEAD_BEEF);
    dmi_wr(7'h05, 32'h0000_1234);
    bus_chk("data1_from_dmi", 20'h384, 32'h0000_1234);

    // Error classes.
    dmi_wr(7'h10, 32'h0003_0001);
    dmi_wr(7'h17, 32'h0022_1000);
    dmi_chk("err_running", 7'h16, 32'h0000_0402);
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_wr(7'h17, 32'h0100_0000);
    dmi_chk("err_cmdtype", 7'h16, 32'h0000_0202);
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_wr(7'h10, 32'h0002_0001);
    dmi_wr(7'h17, 32'h0022_1020);
    dmi_chk("err_fpr",     7'h16, 32'h0000_0202);
    dmi_wr(7'h16, 32'h0000_0700);

    // Transfer=0 is a no-op; mailbox untouched after clearing.
    bus_wr(20'h300, 32'd0);
    bus_chk("req_cleared", 20'h300, 32'h0030_0002);
    dmi_wr(7'h17, 32'h0020_1008);
    dmi_chk("noop_idle",   7'h16, 32'h0000_0002);
    bus_chk("noop_no_req", 20'h300, 32'h0030_0002);

    // Access-memory command ended by exception.
    dmi_wr(7'h17, 32'h0221_0000);
    bus_chk("req_setmem", 20'h300, 32'h8050_0002);
    bus_chk("arg_setmem", 20'h304, 32'h000A_0000);
    bus_wr(20'h314, 32'd0);
    dmi_chk("abscs_except", 7'h16, 32'h0000_0302);
    dmi_wr(7'h16, 32'h0000_0700);

    // DMI data write while busy is rejected.
    dmi_wr(7'h17, 32'h0022_1008);
    dmi_wr(7'h04, 32'h0000_5555);
    dmi_chk("abscs_data_busy", 7'h16, 32'h0000_1102);
    dmi_chk("data0_kept",      7'h04, 32'hDEAD_BEEF);
    bus_wr(20'h310, 32'd0);
    dmi_wr(7'h16, 32'h0000_0700);
    bus_wr(20'h314, 32'd0);
    dmi_chk("except_idle_ignored", 7'h16, 32'h0000_0002);

    // Resume flow for hart 1.
    bus_wr(20'h308, 32'd1);
    dmi_wr(7'h10, 32'h4001_0001);
    bus_chk("req_resume",      20'h300, 32'h8010_0001);
    dmi_chk("dmstatus_h1_hlt", 7'h11, 32'h0000_0300);
    bus_wr(20'h30C, 32'd1);
    dmi_chk("dmstatus_h1_ack", 7'h11, 32'h0003_0C00);
    irq_chk("irq_after_resume", 4'b0001);

    // Unmapped addresses.
    dmi_chk("dmi_unmapped", 7'h20, 32'd0);
    bus_chk("bus_unmapped", 20'h400, 32'd0);
`ifndef DM_AUTOEXEC_EN
    dmi_wr(7'h18, 32'h0000_0001);
    dmi_chk("absauto_absent", 7'h18, 32'd0);
    dmi_chk("data0_no_reissue", 7'h04, 32'hDEAD_BEEF);
    dmi_chk("abscs_no_reissue", 7'h16, 32'h0000_0002);
`endif

    // dmactive=0 clears haltreq/hartsel but keeps data.
    dmi_wr(7'h10, 32'h8000_0000);
    irq_chk("irq_dmactive0", 4'b0000);
    dmi_chk("dmcontrol_clr", 7'h10, 32'h0000_0000);
    dmi_chk("data0_survive", 7'h04, 32'hDEAD_BEEF);
    dmi_wr(7'h10, 32'h0000_0001);

`ifdef DM_AUTOEXEC_EN
    dmi_wr(7'h10, 32'h0002_0001);
    dmi_wr(7'h17, 32'h0022_1008);
    bus_chk("req_getreg", 20'h300, 32'h8020_0002);
    bus_wr(20'h310, 32'd0);
    bus_wr(20'h300, 32'd0);
    dmi_wr(7'h18, 32'h0000_0001);
    dmi_chk("absauto_rb", 7'h18, 32'h0000_0001);
    dmi_chk("auto_data0", 7'h04, 32'hDEAD_BEEF);
    bus_chk("auto_req",   20'h300, 32'h8020_0002);
    dmi_chk("auto_busy",  7'h16, 32'h0000_1002);
    bus_wr(20'h310, 32'd0);
`endif

    // Reset during a command drops it.
    dmi_wr(7'h10, 32'h0002_0001);
    dmi_wr(7'h17, 32'h0022_1008);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    dmi_chk("rst_mid_abscs",   7'h16, 32'h0000_0002);
    bus_chk("rst_mid_request", 20'h300, 32'h0000_0000);
    dmi_chk("rst_mid_status",  7'h11, 32'h0000_0C00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dm_multihart.md
# dm_multihart

Parametrised multi-hart RISC-V debug module core. It bridges the DMI (debug transport side) and the hart-side debug bus, and supports NUM_HART harts and NUM_DATA data registers. It tracks per-hart halt/resume state and runs an abstract-command state machine with busy/cmderr reporting. It posts command requests to a mailbox that the debug ROM (separate block) polls over the bus.

## Interface
- NUM_HART, 4: harts served, 1..16; localparam HSW = max(1, clog2(NUM_HART)).
- NUM_DATA, 2: data registers, 1..12.
- clk  in  1  clock.
- resetn  in  1  reset. One clock; asynchronous, active-low.
- interrupt  out  NUM_HART  per-hart halt request: bit h = haltreq[h].
- dmi_valid / dmi_ready  in/out  1  DMI handshake.
- dmi_write  in  1  1 = write.
- dmi_addr  in  7  register address.
- dmi_wdata / dmi_rdata  in/out  32  write / read data.
- bus_valid / bus_ready  in/out  1  hart bus handshake.
- bus_write  in  1  1 = write.
- bus_addr  in  18  word address [19:2].
- bus_wdata / bus_rdata  in/out  32  write / read data.

## Operation
- DMI map:
  - data0..data(NUM_DATA-1) at 0x04+i.
  - dmcontrol 0x10: [31] haltreq, [30] resumereq, [25:16] hartsello, [0] dmactive.
  - dmstatus 0x11: [17] allresumeack/[16] anyresumeack, [11]/[10] running, [9]/[8] halted, for the selected hart.
  - abstractcs 0x16: [12] busy, [10:8] cmderr W1C, [3:0] datacount=NUM_DATA.
  - command 0x17.
  - All other addresses read 0; writes to them are ignored.
- dmactive=0 clears haltreq, hartsel, abstractcs state and the FSM; data registers and hart_halt are kept.
- haltreq is per hart. A dmcontrol write updates haltreq[hartsel_new] only. hartsel takes wdata[25:16] truncated to HSW.
- resumereq=1 in a dmcontrol write, with the hart halted:
  - clears resumeack[hartsel];
  - posts mailbox number 0x01 (RESUME).
- Bus map (byte address):
  - 0x300 REQUEST: read returns [31] valid, [25:20] number, [19:0] hartid. Any write clears it.
  - 0x304 ARG: read-only; [15:0] regno, [18:16] aarsize, [19] write.
  - 0x308 HALT: write sets hart_halt[wdata].
  - 0x30C RESUME: write clears hart_halt[wdata] and sets resumeack[wdata].
  - 0x310 DONE: write ends the command with success.
  - 0x314 EXCEPT: write ends the command with cmderr=3.
  - 0x380+4i: data i, read/write.
  - Any other address reads 0.
- Request numbers: 0x02 GET_REG, 0x03 SET_REG, 0x04 GET_MEM, 0x05 SET_MEM.
- Command FSM, states IDLE and BUSY. A command write is checked in this priority order:
  1. cmderr≠0: the write is ignored.
  2. BUSY: cmderr=1; the write is ignored.
  3. cmdtype not 0 (access-reg) or 2 (access-mem): cmderr=2.
  4. Access-reg with regno≥0x1020 (FPR): cmderr=2.
  5. Selected hart not halted: cmderr=4.
  6. Access-reg with transfer=0: no-op; stays IDLE.
  7. Otherwise: latch ARG, post the request, go to BUSY.
- BUSY→IDLE on a DONE or EXCEPT bus write. DONE/EXCEPT while IDLE is ignored.
- A DMI write to data i while BUSY sets cmderr=1 if cmderr=0; the data register is unchanged.
- Same-cycle DMI and bus writes to data i: the DMI write wins.
- A resumereq while BUSY is ignored.

## Timing
- Reset values: all outputs 0. haltreq, hart_halt, resumeack, data, mailbox and ARG are 0. FSM in IDLE.
- DMI: dmi_ready rises 1 cycle after dmi_valid and stays high for 1 cycle; the transfer happens when valid && ready. dmi_rdata is registered and valid with dmi_ready.
- Bus: same rules as DMI for bus_valid, bus_ready and bus_rdata.
- Effect of an accepted write:
  - State updates on the accepting edge.
  - busy=1 is visible to the next DMI read.
  - interrupt changes 1 cycle after acceptance.
- Mailbox write-clear and new-post in the same cycle: the post wins.
- Reset asserted mid-command: the FSM returns to IDLE immediately and the pending request is dropped.

## Configuration
- DM_AUTOEXEC_EN defined:
  - Adds abstractauto at DMI 0x18; [NUM_DATA-1:0] = autoexecdata.
  - A DMI read or write of data i with autoexecdata[i]=1, while IDLE and cmderr=0, re-issues the last accepted command through the full checks.
  - A data access while BUSY with the bit set gives cmderr=1.
- DM_AUTOEXEC_EN undefined: 0x18 reads 0, writes are ignored, and no re-issue happens.

## Test plan
- Reset, write dmcontrol=0x1 then 0x8000_0001 with hartsel=0 → interrupt=0b0001. Bus write 0x308 wdata 0 → dmstatus[9:8]=2'b11.
- Hart 2 halted, command=0x0023_1008 (access-reg, write, transfer, s0) → busy=1, bus read 0x300 = 0x8030_0002, ARG=0x000A_1008. Bus write 0x310 → busy=0, cmderr=0.
- Second command while BUSY → cmderr=1, mailbox unchanged. Write abstractcs 0x700 → cmderr=0.
- Command to a running hart → cmderr=4, busy stays 0. Bus write 0x314 during BUSY → cmderr=3.
- resumereq for halted hart 1 → mailbox 0x8010_0001. Bus write 0x30C wdata 1 → dmstatus[17:16]=2'b11, running=1.
- (DM_AUTOEXEC_EN) abstractauto=0x1, last command GET_REG, read data0 → a new request is posted and busy=1.
